// File: rtl/vx_mat_row_fifo_if.sv
// Push-side handshake of the matrix row buffer: a producer offers one packed row
// per cycle and the buffer answers with ready.
interface vx_mat_row_fifo_if #(
  parameter int ROW_W = 128
) ();
  logic             push_valid;
  logic [ROW_W-1:0] push_data;
  logic             push_ready;

  modport master (
    output push_valid,
    output push_data,
    input  push_ready
  );

  modport slave (
    input  push_valid,
    input  push_data,
    output push_ready
  );
endinterface

// File: rtl/vx_mat_row_fifo.sv
// Row-granular operand buffer: a rotatable head row backed by a circular queue of
// DEPTH-1 rows, with rotation counting and a full-revolution pulse.
module vx_mat_row_fifo #(
  parameter int WIDTH   = 32,
  parameter int NUM_REG = 4,
  parameter int DEPTH   = 4,
  parameter int ROT_DIR = 0,
  localparam int ROW_W  = WIDTH * NUM_REG,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int ROT_W  = $clog2(NUM_REG)
) (
  input  logic               clk,
  input  logic               reset,
  vx_mat_row_fifo_if.slave   push,
  input  logic               shift_en,
  input  logic               pop,
  output logic [ROW_W-1:0]   o_data,
  output logic [ROT_W-1:0]   rot_cnt,
  output logic               rot_wrap,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               full,
  output logic               front_full
);

  // A one-slot dummy queue keeps DEPTH=1 legal; it is never written in that case.
  localparam int QD = (DEPTH > 1) ? DEPTH - 1 : 1;
  localparam int QW = (QD > 1) ? $clog2(QD) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [ROT_W-1:0] ROT_LAST  = ROT_W'(NUM_REG - 1);

  logic [ROW_W-1:0] row0_r;
  logic [ROW_W-1:0] q_mem_r [QD];
  logic [QW-1:0]    rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [ROT_W-1:0] rot_cnt_r;
  logic             rot_wrap_r, empty_r, full_r, front_full_r;

  logic [ROW_W-1:0] row0_s;
  logic [QW-1:0]    rd_ptr_s, wr_ptr_s;
  logic [CNT_W-1:0] count_s;
  logic [ROT_W-1:0] rot_cnt_s;
  logic             rot_wrap_s, q_we_s;
  logic             push_ready_s, push_acc_s, pop_acc_s, shift_acc_s;

  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
    if (p == QW'(QD - 1)) begin
      return {QW{1'b0}};
    end else begin
      return p + QW'(1);
    end
  endfunction

  // Element 0 sits at the MSBs, so "toward higher index" is a right rotate of the vector.
  function automatic logic [ROW_W-1:0] rotate_row(input logic [ROW_W-1:0] row);
    if (ROT_DIR == 0) begin
      return {row[WIDTH-1:0], row[ROW_W-1:WIDTH]};
    end else begin
      return {row[ROW_W-WIDTH-1:0], row[ROW_W-1 -: WIDTH]};
    end
  endfunction

  // Next-state selection: pop outranks shift; push lands at the head or the queue tail.
  always_comb begin
    push_ready_s = !full_r || pop;
    push_acc_s   = push.push_valid && push_ready_s;
    pop_acc_s    = pop && !empty_r;
    shift_acc_s  = shift_en && front_full_r && !pop;
    row0_s       = row0_r;
    rd_ptr_s     = rd_ptr_r;
    wr_ptr_s     = wr_ptr_r;
    count_s      = count_r;
    rot_cnt_s    = rot_cnt_r;
    rot_wrap_s   = 1'b0;
    q_we_s       = 1'b0;
    if (pop_acc_s) begin
      rot_cnt_s = {ROT_W{1'b0}};
      if (count_r > CNT_W'(1)) begin
        row0_s   = q_mem_r[rd_ptr_r];
        rd_ptr_s = ptr_inc(rd_ptr_r);
        if (push_acc_s) begin
          q_we_s   = 1'b1;
          wr_ptr_s = ptr_inc(wr_ptr_r);
        end else begin
          q_we_s   = 1'b0;
        end
      end else if (push_acc_s) begin
        row0_s = push.push_data;
      end else begin
        row0_s = row0_r;
      end
      if (push_acc_s) begin
        count_s = count_r;
      end else begin
        count_s = count_r - CNT_W'(1);
      end
    end else begin
      if (shift_acc_s) begin
        row0_s     = rotate_row(row0_r);
        rot_wrap_s = (rot_cnt_r == ROT_LAST);
        rot_cnt_s  = (rot_cnt_r == ROT_LAST) ? {ROT_W{1'b0}} : rot_cnt_r + ROT_W'(1);
      end else begin
        rot_wrap_s = 1'b0;
      end
      if (push_acc_s) begin
        if (empty_r) begin
          row0_s = push.push_data;
        end else begin
          q_we_s   = 1'b1;
          wr_ptr_s = ptr_inc(wr_ptr_r);
        end
        count_s = count_r + CNT_W'(1);
      end else begin
        count_s = count_r;
      end
    end
  end

  // State and status registers; status flags are derived from the next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      row0_r       <= {ROW_W{1'b0}};
      rd_ptr_r     <= {QW{1'b0}};
      wr_ptr_r     <= {QW{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      rot_cnt_r    <= {ROT_W{1'b0}};
      rot_wrap_r   <= 1'b0;
      empty_r      <= 1'b1;
      full_r       <= 1'b0;
      front_full_r <= 1'b0;
    end else begin
      row0_r       <= row0_s;
      rd_ptr_r     <= rd_ptr_s;
      wr_ptr_r     <= wr_ptr_s;
      count_r      <= count_s;
      rot_cnt_r    <= rot_cnt_s;
      rot_wrap_r   <= rot_wrap_s;
      empty_r      <= (count_s == {CNT_W{1'b0}});
      full_r       <= (count_s == DEPTH_C);
      front_full_r <= (count_s != {CNT_W{1'b0}});
    end
  end

  // Queued row storage, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QD; i++) begin
        q_mem_r[i] <= {ROW_W{1'b0}};
      end
    end else if (q_we_s) begin
      q_mem_r[wr_ptr_r] <= push.push_data;
    end else begin
      q_mem_r[wr_ptr_r] <= q_mem_r[wr_ptr_r];
    end
  end

  assign push.push_ready = push_ready_s;
  assign o_data          = row0_r;
  assign rot_cnt         = rot_cnt_r;
  assign rot_wrap        = rot_wrap_r;
  assign count           = count_r;
  assign empty           = empty_r;
  assign full            = full_r;
  assign front_full      = front_full_r;

endmodule
